// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types.
package cpu_pkg;

  // IF/ID pipeline register payload: fetch address plus instruction word.
  typedef struct packed {
    logic [31:0] pc_address;
    logic [31:0] instruc;
  } if_id_data_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, buffers a response that lands during a stall, and
// squashes in-flight work on a branch redirect from MEM.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output if_id_data_t if_id_o,
  output logic        if_id_valid_o
);

  // FETCH: idle, WAIT: request in flight, HOLD: response parked during a
  // stall, DROP: in-flight response belongs to a squashed path.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  if_id_data_t if_id_q, if_id_d;
  logic        valid_q, valid_d;
  logic        req_c;
  logic [31:0] addr_c;
  logic [31:0] pc_next;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC wraps modulo 2^32.
  assign pc_next = pc_q + 32'd4;

  // Next-state, PC, buffer and IF/ID update plus the combinational request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if_id_d = if_id_q;
    // A stall freezes the valid bit; otherwise it drops unless an
    // instruction is delivered below.
    valid_d = stall_i ? valid_q : 1'b0;
    req_c   = 1'b0;
    addr_c  = pc_q;

    if (branch_taken_i) begin
      // Redirect wins over everything: flush IF/ID even under stall and
      // never issue a request in the same cycle.
      pc_d    = word_align(branch_target_i);
      valid_d = 1'b0;
      case (state_q)
        S_WAIT, S_DROP: state_d = imem_rvalid_i ? S_FETCH : S_DROP;
        default:        state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (stall_i) begin
              buf_d   = imem_rdata_i;
              state_d = S_HOLD;
            end else begin
              // Deliver and chain the next request in the same cycle so a
              // single-cycle memory sustains one instruction per clock.
              if_id_d.pc_address = pc_q;
              if_id_d.instruc    = imem_rdata_i;
              valid_d            = 1'b1;
              pc_d               = pc_next;
              req_c              = 1'b1;
              addr_c             = pc_next;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            if_id_d.pc_address = pc_q;
            if_id_d.instruc    = buf_q;
            valid_d            = 1'b1;
            pc_d               = pc_next;
            state_d            = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Register FSM state, PC, hold buffer and the IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= word_align(RESET_PC);
      buf_q   <= '0;
      if_id_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
    end
  end

  // Memory shares rst_n, so the request is masked while reset is held.
  assign imem_req_o    = req_c & rst_n;
  assign imem_addr_o   = addr_c;
  assign if_id_o       = if_id_q;
  assign if_id_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, multi-cycle corner
// sequences and a long random run, all scored against a behavioural model.
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;

  logic        a_req;
  logic [31:0] a_addr;
  logic        a_rvalid = 1'b0;
  logic [31:0] a_rdata = 32'h0;
  if_id_data_t a_ifid;
  logic        a_vld;

  logic        b_req;
  logic [31:0] b_addr;
  logic        b_rvalid = 1'b0;
  logic [31:0] b_rdata = 32'h0;
  if_id_data_t b_ifid;
  logic        b_vld;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_req_o(a_req), .imem_addr_o(a_addr),
    .imem_rvalid_i(a_rvalid), .imem_rdata_i(a_rdata),
    .if_id_o(a_ifid), .if_id_valid_o(a_vld)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_req_o(b_req), .imem_addr_o(b_addr),
    .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
    .if_id_o(b_ifid), .if_id_valid_o(b_vld)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Memory model for DUT A (configurable latency) and DUT B (1 cycle).
  bit          a_pend = 1'b0;
  int          a_rem = 0;
  logic [31:0] a_data = 32'h0;
  int          a_lat_min = 1;
  int          a_lat_max = 1;
  bit          rand_data = 1'b0;
  bit          b_pend = 1'b0;
  logic [31:0] b_data = 32'h0;
  logic [31:0] b_addrs[$];
  bit          b_log = 1'b0;

  logic        seen_req = 1'b0;
  logic [31:0] seen_addr = 32'h0;
  logic        b_seen_req = 1'b0;
  logic [31:0] b_seen_addr = 32'h0;

  // Behavioural reference: next PC, an in-flight flag, a flag saying the
  // in-flight word is unwanted, and a one-deep queue of parked words.
  logic [31:0] m_pc = 32'h0;
  bit          m_inflight = 1'b0;
  bit          m_unwanted = 1'b0;
  logic [31:0] m_held[$];
  if_id_data_t m_out = '0;
  logic        m_ov = 1'b0;
  logic        exp_req = 1'b0;
  logic [31:0] exp_addr = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_step(input logic rn, input logic st, input logic br,
                            input logic [31:0] tgt, input logic rv, input logic [31:0] rd);
    exp_req  = 1'b0;
    exp_addr = m_pc;
    if (!rn) begin
      m_pc = 32'h0; m_inflight = 1'b0; m_unwanted = 1'b0;
      m_held.delete(); m_out = '0; m_ov = 1'b0;
      return;
    end
    if (br) begin
      if (m_inflight && rv) m_inflight = 1'b0;
      m_unwanted = m_inflight;
      m_held.delete();
      m_pc = tgt & ~32'h3;
      m_ov = 1'b0;
    end else if (m_held.size() != 0) begin
      if (!st) begin
        m_out.pc_address = m_pc;
        m_out.instruc    = m_held.pop_front();
        m_ov = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_inflight) begin
      if (!rv) begin
        m_ov = st ? m_ov : 1'b0;
      end else if (m_unwanted) begin
        m_inflight = 1'b0; m_unwanted = 1'b0;
        m_ov = st ? m_ov : 1'b0;
      end else if (st) begin
        m_held.push_back(rd);
        m_inflight = 1'b0;
      end else begin
        m_out.pc_address = m_pc;
        m_out.instruc    = rd;
        m_ov = 1'b1;
        m_pc = m_pc + 32'd4;
        exp_req = 1'b1;
        exp_addr = m_pc;
      end
    end else begin
      exp_req = 1'b1;
      exp_addr = m_pc;
      m_inflight = 1'b1;
      m_ov = st ? m_ov : 1'b0;
    end
  endtask

  // One clock: drive inputs, check the combinational request, clock,
  // update the memories, check the IF/ID register against the model.
  task automatic cyc(input logic rn, input logic st, input logic br, input logic [31:0] tgt);
    rst_n = rn; stall_i = st; branch_taken_i = br; branch_target_i = tgt;
    a_rvalid = a_pend && (a_rem == 0);
    a_rdata  = a_data;
    b_rvalid = b_pend;
    b_rdata  = b_data;
    #1;
    seen_req = a_req; seen_addr = a_addr;
    b_seen_req = b_req; b_seen_addr = b_addr;
    model_step(rn, st, br, tgt, a_rvalid, a_rdata);
    chk("imem_req", 64'(seen_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", 64'(seen_addr), 64'(exp_addr));
    chk("single_outstanding", 64'(seen_req && a_pend && !a_rvalid), 64'd0);
    if (b_log && b_seen_req) b_addrs.push_back(b_seen_addr);
    @(posedge clk);
    #1;
    if (!rn) begin
      a_pend = 1'b0; b_pend = 1'b0;
    end else begin
      if (a_rvalid) a_pend = 1'b0;
      else if (a_pend) a_rem--;
      if (seen_req) begin
        a_pend = 1'b1;
        a_rem  = int'($urandom_range(a_lat_max - 1, a_lat_min - 1));
        a_data = rand_data ? $urandom : (seen_addr ^ 32'hA5A5_0000);
      end
      if (b_rvalid) b_pend = 1'b0;
      if (b_seen_req) begin
        b_pend = 1'b1;
        b_data = b_seen_addr ^ 32'hA5A5_0000;
      end
    end
    chk("if_id_valid", 64'(a_vld), 64'(m_ov));
    chk("if_id", 64'(a_ifid), 64'(m_out));
    @(negedge clk);
  endtask

  typedef struct {
    logic        rn, st, br;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc, eins;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit found;
    bit saw_10;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'hA5A5_0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'hA5A5_0004};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'hA5A5_0004};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'hA5A5_0004};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   32'hA5A5_0004};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   32'hA5A5_0008};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h8,   32'hA5A5_0008};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'hA5A5_000C};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10,  32'hA5A5_0010};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   1'b0, 32'h10,  32'hA5A5_0010};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h10,  32'hA5A5_0010};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200};

    // Directed table: 1-cycle memory, stall on the 0x8 response, then a
    // redirect coinciding with a stall.
    a_lat_min = 1; a_lat_max = 1; rand_data = 1'b0; b_log = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rn, tbl[i].st, tbl[i].br, tbl[i].tgt);
      chk($sformatf("tbl%0d_req", i), 64'(seen_req), 64'(tbl[i].ereq));
      if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), 64'(seen_addr), 64'(tbl[i].eaddr));
      chk($sformatf("tbl%0d_vld", i), 64'(a_vld), 64'(tbl[i].evld));
      chk($sformatf("tbl%0d_if_id", i), 64'(a_ifid), {tbl[i].epc, tbl[i].eins});
      if (i == 1) begin
        chk("b_reset_vld", 64'(b_vld), 64'd0);
        chk("b_reset_if_id", 64'(b_ifid), 64'd0);
      end
    end
    b_log = 1'b0;

    // Second instance starts at 0xFFFF_FFF8 and must wrap through zero.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want;
      logic [31:0] got;
      want = 32'hFFFF_FFF8 + 32'(4 * k);
      got  = (k < b_addrs.size()) ? b_addrs[k] : 32'hDEAD_BEEF;
      chk($sformatf("wrap_addr%0d", k), 64'(got), 64'(want));
    end

    // 3-cycle memory, redirect one cycle after the request to 0x10.
    a_lat_min = 3; a_lat_max = 3;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (seen_req && seen_addr == 32'h10) found = 1'b1;
    end
    chk("br_req10_seen", 64'(found), 64'd1);
    cyc(1'b1, 1'b0, 1'b1, 32'h103);
    chk("br_cycle_no_req", 64'(seen_req), 64'd0);
    chk("br_flush_vld", 64'(a_vld), 64'd0);
    found = 1'b0; saw_10 = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (a_vld && a_ifid.pc_address == 32'h10) saw_10 = 1'b1;
      if (seen_req) found = 1'b1;
    end
    chk("br_next_req_seen", 64'(found), 64'd1);
    chk("br_next_addr", 64'(seen_addr), 64'h100);
    chk("br_0x10_dropped", 64'(saw_10), 64'd0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (a_vld) found = 1'b1;
    end
    chk("br_target_vld", 64'(found), 64'd1);
    chk("br_target_if_id", 64'(a_ifid), {32'h100, 32'hA5A5_0100});

    // Reset asserted while a response is parked in HOLD.
    a_lat_min = 1; a_lat_max = 1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_no_req", 64'(seen_req), 64'd0);
    chk("hold_vld", 64'(a_vld), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_hold_vld", 64'(a_vld), 64'd0);
    chk("rst_hold_if_id", 64'(a_ifid), 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_hold_req", 64'(seen_req), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_first_req", 64'(seen_req), 64'd1);
    chk("rst_first_addr", 64'(seen_addr), 64'h0);

    // Random run: variable latency, random data, stalls, redirects, resets.
    a_lat_min = 1; a_lat_max = 4; rand_data = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3000; k++) begin
      logic rn, st, br;
      rn = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 8);
      cyc(rn, st, br, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues fetches to instruction memory, and drives the IF/ID pipeline register.
- Output payload is `cpu_pkg::if_id_data_t` (`pc_address`, `instruc`) plus a valid bit, consumed by decode.
- Accepts stall from the hazard unit and branch redirect from the MEM stage.
- At most one outstanding memory request; response latency is variable (≥1 cycle).

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall_i`  in  1  hazard unit: hold the IF/ID contents; do not accept a new instruction.
- `branch_taken_i`  in  1  MEM-stage redirect strobe (one cycle).
- `branch_target_i`  in  32  redirect address; bits [1:0] ignored (treated as 00).
- `imem_req_o`  out  1  fetch request; accepted by memory in the cycle it is high.
- `imem_addr_o`  out  32  fetch address, word aligned.
- `imem_rvalid_i`  in  1  response valid; exactly one per accepted request.
- `imem_rdata_i`  in  32  instruction word, valid with `imem_rvalid_i`.
- `if_id_o`  out  64  `cpu_pkg::if_id_data_t` register: {`pc_address`, `instruc`}.
- `if_id_valid_o`  out  1  `if_id_o` holds a live instruction.

Behaviour:
- Reset (`rst_n`=0 at edge):
  - `pc_q` = `RESET_PC`, state = FETCH, hold buffer cleared.
  - `if_id_o` = 0, `if_id_valid_o` = 0.
  - `imem_req_o` = 0 while `rst_n` is low.
  - Instruction memory shares `rst_n`, so no stale response survives reset; mid-operation reset discards all in-flight state.
- `pc_q` is the address of the instruction currently requested or held. Arithmetic is 32-bit modulo: `32'hFFFF_FFFC` + 4 = 0.
- States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding.
  - HOLD: response buffered while stalled.
  - DROP: outstanding response is to be discarded.
- Priority each cycle: reset > `branch_taken_i` > response handling > stall.
- FETCH:
  - `imem_req_o`=1, `imem_addr_o`=`pc_q` → WAIT.
  - If `branch_taken_i`: `imem_req_o`=0, `pc_q` ← target, stay FETCH.
  - `imem_rvalid_i` is ignored in this state.
- WAIT, `imem_rvalid_i`=0: stay WAIT.
- WAIT, `imem_rvalid_i`=1, `stall_i`=0:
  - `if_id_o` ← {`pc_q`, `imem_rdata_i`}, `if_id_valid_o` ← 1, `pc_q` ← `pc_q`+4.
  - Same cycle (combinational): `imem_req_o`=1, `imem_addr_o`=`pc_q`+4; stay WAIT.
  - Steady state with 1-cycle memory therefore gives one instruction per cycle.
- WAIT, `imem_rvalid_i`=1, `stall_i`=1: buffer `imem_rdata_i`, no new request → HOLD.
- HOLD:
  - `stall_i`=1: stay HOLD.
  - `stall_i`=0: `if_id_o` ← {`pc_q`, buffer}, valid ← 1, `pc_q` += 4 → FETCH.
- Redirect (`branch_taken_i`=1):
  - `pc_q` ← {target[31:2], 2'b00}; `if_id_valid_o` ← 0 (flush, even if `stall_i`=1); payload unchanged.
  - From WAIT with `imem_rvalid_i`=0 → DROP.
  - From WAIT with `imem_rvalid_i`=1 → response discarded → FETCH.
  - From HOLD → buffer discarded → FETCH.
  - From DROP with `imem_rvalid_i`=0 → stay DROP (new target kept).
  - From DROP with `imem_rvalid_i`=1 → FETCH.
  - No request is issued in a redirect cycle.
- DROP:
  - No request issued.
  - On `imem_rvalid_i`=1: discard data → FETCH.
  - `stall_i` has no effect.
- Stall without redirect: `if_id_o` and `if_id_valid_o` hold their values.
- Not stalled and no instruction delivered this cycle: `if_id_valid_o` ← 0 (bubble); payload holds.

Test Plan:
- Reset, 1-cycle memory returning `addr^32'hA5A5_0000`:
  - Requests go to 0, 4, 8, … on consecutive cycles after the first.
  - `if_id_o` shows {0, `0xA5A5_0000`} with valid=1 two cycles after reset release, then one instruction per cycle.
- Hold `stall_i`=1 for 3 cycles when the response for 0x8 arrives:
  - `if_id_o` holds {4, …} through the stall.
  - No request while in HOLD.
  - After release, {8, `0xA5A5_0008`} appears, then a request to 0xC.
- 3-cycle memory, `branch_taken_i`=1 target 0x103 one cycle after the request to 0x10:
  - The 0x10 response is dropped and valid goes to 0.
  - Next request is to 0x100; `if_id_o` then shows {0x100, …}.
- `branch_taken_i`=1 and `stall_i`=1 in the same cycle with valid=1:
  - `if_id_valid_o`=0 next cycle.
  - Next request is to the target.
- `RESET_PC`=`32'hFFFF_FFF8`:
  - Fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `rst_n`=0 during HOLD:
  - Next cycle valid=0, `imem_req_o`=0.
  - After release, first request is to `RESET_PC`.
